// File: rtl/trading_engine_pp.sv
// rtl/trading_engine_pp.sv - market-data packet parser with theo CAM and offset-based trade decision
module trading_engine_pp #(
  parameter int DEPTH          = 16,
  parameter int PRODUCT_OFFSET = 30,
  parameter int PRICE_OFFSET   = 34,
  parameter int SIDE_OFFSET    = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] product_num,
  input  logic [31:0] product_theo,
  input  logic        product_theo_valid,
  input  logic [7:0]  tcp_data,
  input  logic        tcp_valid,
  input  logic        tcp_sop,
  input  logic        tcp_eop,
  input  logic [31:0] px_offset,
  input  logic [1:0]  px_offset_sel,
  input  logic        px_offset_valid,
  output logic        trade,
  output logic        trade_buy,
  output logic [15:0] trade_product,
  output logic [31:0] trade_price,
  output logic        pkt_drop,
  output logic        table_full
);
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [1:0] S_IDLE = 2'd0, S_RECV = 2'd1, S_LOOKUP = 2'd2;
  localparam logic [15:0] PROD_B = PRODUCT_OFFSET[15:0];
  localparam logic [15:0] PRICE_B = PRICE_OFFSET[15:0];
  localparam logic [15:0] SIDE_B = SIDE_OFFSET[15:0];

  logic [DEPTH-1:0] ent_valid;
  logic [15:0]      ent_key  [DEPTH];
  logic [31:0]      ent_theo [DEPTH];
  logic [31:0]      buy_off, sell_off;
  logic             buy_armed, sell_armed;
  logic [1:0]       state;
  logic [15:0]      count;
  logic [15:0]      cap_product, cap_product_n, lk_product;
  logic [31:0]      cap_price, cap_price_n, lk_price;
  logic             cap_side, cap_side_n, lk_side;

  logic          wr_hit, free_ok, lk_hit;
  logic [IW-1:0] wr_idx, free_idx;
  logic [31:0]   lk_theo;

  // Descending scans leave the lowest matching / free index selected.
  always_comb begin
    wr_hit   = 1'b0;
    wr_idx   = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    lk_hit   = 1'b0;
    lk_theo  = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (ent_valid[i] && ent_key[i] == product_num) begin
        wr_hit = 1'b1;
        wr_idx = IW'(i);
      end
      if (!ent_valid[i]) begin
        free_ok  = 1'b1;
        free_idx = IW'(i);
      end
      if (ent_valid[i] && ent_key[i] == lk_product) begin
        lk_hit  = 1'b1;
        lk_theo = ent_theo[i];
      end
    end
  end

  assign table_full = &ent_valid;

  logic        in_pkt, pkt_end, runt, go_lookup;
  logic [15:0] idx, next_count;

  always_comb begin
    in_pkt        = tcp_sop || (state == S_RECV);
    idx           = tcp_sop ? 16'd0 : count;
    next_count    = (tcp_valid && idx != 16'hFFFF) ? idx + 16'd1 : idx;
    cap_product_n = cap_product;
    cap_price_n   = cap_price;
    cap_side_n    = cap_side;
    if (tcp_valid) begin
      if (idx == PROD_B)           cap_product_n[15:8] = tcp_data;
      if (idx == PROD_B + 16'd1)   cap_product_n[7:0]  = tcp_data;
      if (idx == PRICE_B)          cap_price_n[31:24]  = tcp_data;
      if (idx == PRICE_B + 16'd1)  cap_price_n[23:16]  = tcp_data;
      if (idx == PRICE_B + 16'd2)  cap_price_n[15:8]   = tcp_data;
      if (idx == PRICE_B + 16'd3)  cap_price_n[7:0]    = tcp_data;
      if (idx == SIDE_B)           cap_side_n          = tcp_data[0];
    end
    pkt_end   = in_pkt && tcp_eop;
    runt      = pkt_end && (tcp_sop || next_count <= SIDE_B);
    go_lookup = pkt_end && !runt;
  end

  logic [32:0] sell_limit;
  logic        sell_hit, buy_hit, do_trade, lk_drop;

  always_comb begin
    sell_limit = {1'b0, lk_theo} + {1'b0, sell_off};
    sell_hit   = sell_armed && ({1'b0, lk_price} >= sell_limit);
    buy_hit    = buy_armed && (buy_off <= lk_theo) && (lk_price <= lk_theo - buy_off);
    do_trade   = (state == S_LOOKUP) && lk_hit && (lk_side ? sell_hit : buy_hit);
    lk_drop    = (state == S_LOOKUP) && !lk_hit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent_valid     <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_key[i]  <= '0;
        ent_theo[i] <= '0;
      end
      buy_off       <= '0;
      sell_off      <= '0;
      buy_armed     <= 1'b0;
      sell_armed    <= 1'b0;
      state         <= S_IDLE;
      count         <= '0;
      cap_product   <= '0;
      cap_price     <= '0;
      cap_side      <= 1'b0;
      lk_product    <= '0;
      lk_price      <= '0;
      lk_side       <= 1'b0;
      trade         <= 1'b0;
      trade_buy     <= 1'b0;
      trade_product <= '0;
      trade_price   <= '0;
      pkt_drop      <= 1'b0;
    end else begin
      if (product_theo_valid) begin
        if (wr_hit) begin
          ent_theo[wr_idx] <= product_theo;
        end else if (free_ok) begin
          ent_valid[free_idx] <= 1'b1;
          ent_key[free_idx]   <= product_num;
          ent_theo[free_idx]  <= product_theo;
        end
      end
      if (px_offset_valid && px_offset_sel[0]) begin
        buy_off   <= px_offset;
        buy_armed <= 1'b1;
      end
      if (px_offset_valid && px_offset_sel[1]) begin
        sell_off   <= px_offset;
        sell_armed <= 1'b1;
      end

      if (in_pkt) begin
        count       <= next_count;
        cap_product <= cap_product_n;
        cap_price   <= cap_price_n;
        cap_side    <= cap_side_n;
        if (pkt_end) begin
          state <= go_lookup ? S_LOOKUP : S_IDLE;
          if (go_lookup) begin
            lk_product <= cap_product_n;
            lk_price   <= cap_price_n;
            lk_side    <= cap_side_n;
          end
        end else begin
          state <= S_RECV;
        end
      end else begin
        state <= S_IDLE;
      end

      trade <= do_trade;
      if (do_trade) begin
        trade_buy     <= !lk_side;
        trade_product <= lk_product;
        trade_price   <= lk_price;
      end
      // A runt ending during a trading LOOKUP loses its drop pulse so the two never overlap.
      pkt_drop <= !do_trade && (lk_drop || runt);
    end
  end
endmodule
